// File: rtl/rs_encoder_pkg.sv
// Reed-Solomon helpers shared by the encoder: GF(2^m) multiply, the generator
// polynomial builder evaluated at elaboration, and the encoder state type.
package reed_solomon;

    localparam int MAX_SYMBOL_BITS = 12;
    localparam int MAX_PARITY      = 64;

    typedef enum logic [0:0] {
        DATA   = 1'b0,
        PARITY = 1'b1
    } rs_state_e;

    // g[0..2t], one coefficient per slot, lowest degree in slot 0.
    typedef logic [MAX_PARITY:0][MAX_SYMBOL_BITS-1:0] rs_poly_t;

    function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                           input int m, input int unsigned prim);
        int unsigned p;
        int unsigned x;
        p = 0;
        x = a;
        for (int i = 0; i < m; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x[m]) x = x ^ prim;
        end
        return p;
    endfunction

    function automatic rs_poly_t rs_gen_poly(input int m, input int unsigned prim,
                                             input int t, input int b0);
        rs_poly_t    g;
        int unsigned root;
        g    = '0;
        g[0] = MAX_SYMBOL_BITS'(1);
        root = 1;
        for (int k = 0; k < b0; k++) root = gf_mul(root, 2, m, prim);
        // Multiply in one (x + alpha^(b0+k)) factor per pass.
        for (int k = 0; k < 2 * t; k++) begin
            for (int i = 2 * t; i > 0; i--) begin
                g[i] = g[i-1] ^ MAX_SYMBOL_BITS'(gf_mul(32'(g[i]), root, m, prim));
            end
            g[0] = MAX_SYMBOL_BITS'(gf_mul(32'(g[0]), root, m, prim));
            root = gf_mul(root, 2, m, prim);
        end
        return g;
    endfunction

endpackage

// File: rtl/rs_encoder_if.sv
// Symbol stream around the RS encoder: message in, codeword out, plus framing status.
interface rs_encoder_if #(
    parameter int SYMBOL_BITS = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [SYMBOL_BITS-1:0] s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [SYMBOL_BITS-1:0] m_data;
    logic                   m_parity;
    logic                   m_last;
    logic                   len_err;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_parity, m_last, len_err
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_parity, m_last, len_err
    );
endinterface

// File: rtl/rs_encoder_gf_const_mult.sv
// Multiply by a field constant: each set input bit contributes CONST * x^j,
// so the whole block reduces to a fixed XOR network.
module gf_const_mult
    import reed_solomon::*;
#(
    parameter int          SYMBOL_BITS = 8,
    parameter int unsigned PRIM_POLY   = 'h11D,
    parameter int unsigned CONST       = 1
) (
    input  logic [SYMBOL_BITS-1:0] a,
    output logic [SYMBOL_BITS-1:0] p
);
    always_comb begin
        // NOTE: p gets a default before the loop so every path assigns it and no latch is inferred.
        p = '0;
        for (int j = 0; j < SYMBOL_BITS; j++) begin
            if (a[j]) p = p ^ SYMBOL_BITS'(gf_mul(CONST, 32'(1) << j, SYMBOL_BITS, PRIM_POLY));
        end
    end
endmodule

// File: rtl/rs_encoder.sv
// Streaming systematic RS encoder: message symbols pass straight through, then
// 2t parity symbols are shifted out of an LFSR that divides by g(x).
module rs_encoder
    import reed_solomon::*;
#(
    parameter int          SYMBOL_BITS         = 8,
    parameter int          CORRECTION_CAPACITY = 8,
    parameter int          BLOCK_LENGTH        = 255,
    parameter int unsigned PRIM_POLY           = 'h11D,
    parameter int          B0                  = 0
) (
    input logic         clk,
    input logic         rst,
    rs_encoder_if.slave io
);
    localparam int PARITY_LEN     = 2 * CORRECTION_CAPACITY;
    localparam int MESSAGE_LENGTH = BLOCK_LENGTH - PARITY_LEN;
    localparam int MW = $clog2((MESSAGE_LENGTH > 0) ? MESSAGE_LENGTH + 1 : 2);
    localparam int PW = $clog2(PARITY_LEN + 1);
    localparam logic [MW-1:0] MSG_LAST = MW'(MESSAGE_LENGTH - 1);
    localparam logic [PW-1:0] PAR_LAST = PW'(PARITY_LEN - 1);
    localparam rs_poly_t GEN = rs_gen_poly(SYMBOL_BITS, PRIM_POLY, CORRECTION_CAPACITY, B0);

    if (MESSAGE_LENGTH < 1) begin : g_bad_length
        $error("rs_encoder: BLOCK_LENGTH must exceed 2*CORRECTION_CAPACITY");
    end
    if (BLOCK_LENGTH > (1 << SYMBOL_BITS) - 1) begin : g_bad_block
        $error("rs_encoder: BLOCK_LENGTH exceeds 2^SYMBOL_BITS-1");
    end
    if (SYMBOL_BITS < 3 || SYMBOL_BITS > MAX_SYMBOL_BITS || PARITY_LEN > MAX_PARITY) begin : g_bad_size
        $error("rs_encoder: SYMBOL_BITS or CORRECTION_CAPACITY out of range");
    end

    rs_state_e              state;
    logic [MW-1:0]          msg_cnt;
    logic [PW-1:0]          par_cnt;
    logic                   len_err;
    logic [SYMBOL_BITS-1:0] r    [PARITY_LEN];
    logic [SYMBOL_BITS-1:0] prod [PARITY_LEN];
    logic [SYMBOL_BITS-1:0] fb;
    logic                   msg_xfer;
    logic                   par_xfer;
    logic                   last_msg;

    assign fb       = io.s_data ^ r[PARITY_LEN-1];
    assign msg_xfer = (state == DATA) && io.s_valid && io.m_ready;
    assign par_xfer = (state == PARITY) && io.m_ready;
    assign last_msg = (msg_cnt == MSG_LAST);

    for (genvar i = 0; i < PARITY_LEN; i++) begin : g_mult
        gf_const_mult #(
            .SYMBOL_BITS(SYMBOL_BITS),
            .PRIM_POLY  (PRIM_POLY),
            .CONST      (32'(GEN[i]))
        ) u_mult (
            .a(fb),
            .p(prod[i])
        );
    end

    // Reset forces both handshakes low regardless of state.
    always_comb begin
        io.s_ready  = 1'b0;
        io.m_valid  = 1'b0;
        io.m_data   = r[PARITY_LEN-1];
        io.m_parity = 1'b0;
        io.m_last   = 1'b0;
        if (state == DATA) begin
            io.s_ready = io.m_ready & ~rst;
            io.m_valid = io.s_valid & ~rst;
            io.m_data  = io.s_data;
        end else begin
            io.m_valid  = ~rst;
            io.m_parity = 1'b1;
            io.m_last   = (par_cnt == PAR_LAST);
        end
    end

    assign io.len_err = len_err;

    // NOTE: non-blocking assignments, so every r[i] sees its neighbour's pre-edge value during the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DATA;
            msg_cnt <= '0;
            par_cnt <= '0;
            len_err <= 1'b0;
            // NOTE: the LFSR array is cleared on reset; an abandoned codeword must leave no residue.
            for (int i = 0; i < PARITY_LEN; i++) r[i] <= '0;
        end else begin
            len_err <= msg_xfer & (io.s_last ^ last_msg);
            if (msg_xfer) begin
                r[0] <= prod[0];
                for (int i = 1; i < PARITY_LEN; i++) r[i] <= r[i-1] ^ prod[i];
                if (last_msg) begin
                    msg_cnt <= '0;
                    state   <= PARITY;
                end else begin
                    msg_cnt <= msg_cnt + MW'(1);
                end
            end else if (par_xfer) begin
                // Shifting zeros in leaves the LFSR clear for the next codeword.
                r[0] <= '0;
                for (int i = 1; i < PARITY_LEN; i++) r[i] <= r[i-1];
                if (par_cnt == PAR_LAST) begin
                    par_cnt <= '0;
                    state   <= DATA;
                end else begin
                    par_cnt <= par_cnt + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench: a GF(16) t=1 instance with hand-computed parity, and the default
// RS(255,239) instance checked against a long-division model and codeword syndromes.
module tb_rs_encoder;
    localparam int N = 255;
    localparam int K = 239;
    localparam int P = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    rs_encoder_if #(.SYMBOL_BITS(8)) big_if ();
    rs_encoder_if #(.SYMBOL_BITS(4)) sm_if ();

    rs_encoder u_big (
        .clk(clk),
        .rst(rst),
        .io (big_if)
    );

    rs_encoder #(
        .SYMBOL_BITS        (4),
        .CORRECTION_CAPACITY(1),
        .BLOCK_LENGTH       (15),
        .PRIM_POLY          ('h13),
        .B0                 (0)
    ) u_small (
        .clk(clk),
        .rst(rst),
        .io (sm_if)
    );

    logic [7:0] exp_tab [0:509];
    int         log_tab [0:255];
    logic [7:0] gen     [0:P];
    logic [7:0] msg     [0:K-1];
    logic [7:0] exp_cw  [0:N-1];
    logic [7:0] obs_cw  [0:N-1];
    logic [7:0] ref_cw  [0:N-1];
    int out_cnt, par_cycles, first_par, last_cnt, last_idx, len_err_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return exp_tab[log_tab[a] + log_tab[b]];
    endfunction

    task automatic build_field();
        logic [8:0] x;
        x = 9'd1;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i]       = x[7:0];
            exp_tab[i + 255] = x[7:0];
            log_tab[x[7:0]]  = i;
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
        log_tab[0] = 0;
        for (int i = 0; i <= P; i++) gen[i] = 8'd0;
        gen[0] = 8'd1;
        for (int j = 0; j < P; j++) begin
            for (int i = P; i > 0; i--) gen[i] = gen[i-1] ^ tb_mul(gen[i], exp_tab[j]);
            gen[0] = tb_mul(gen[0], exp_tab[j]);
        end
    endtask

    // Textbook long division of m(x)*x^16 by g(x); the remainder is the parity.
    task automatic build_expected();
        logic [7:0] work [0:N-1];
        logic [7:0] coef;
        for (int i = 0; i < N; i++) work[i] = (i < K) ? msg[i] : 8'd0;
        for (int i = 0; i < K; i++) begin
            coef = work[i];
            for (int j = 0; j <= P; j++) work[i+j] = work[i+j] ^ tb_mul(coef, gen[P-j]);
        end
        for (int i = 0; i < N; i++) exp_cw[i] = (i < K) ? msg[i] : work[i];
    endtask

    function automatic int bad_syndromes();
        logic [7:0] s;
        int bad = 0;
        for (int j = 0; j < P; j++) begin
            s = 8'd0;
            for (int i = 0; i < N; i++) s = tb_mul(s, exp_tab[j]) ^ obs_cw[i];
            if (s != 8'd0) bad++;
        end
        return bad;
    endfunction

    function automatic int cw_mismatches();
        int n = 0;
        for (int i = 0; i < N; i++) if (obs_cw[i] !== exp_cw[i]) n++;
        return n;
    endfunction

    // Drives one codeword into the big instance with bp percent stall probability on
    // both handshakes and records every output transfer until stop_after of them.
    task automatic send_big(input int bp, input int last_at, input int stop_after);
        int in_idx = 0;
        int cyc    = 0;
        out_cnt = 0; par_cycles = 0; first_par = -1;
        last_cnt = 0; last_idx = -1; len_err_cnt = 0;
        for (int i = 0; i < N; i++) obs_cw[i] = 8'hxx;
        while (out_cnt < stop_after && cyc < 4000) begin
            @(negedge clk);
            big_if.s_valid = (in_idx < K) && (int'($urandom_range(99)) >= bp);
            big_if.s_data  = big_if.s_valid ? msg[in_idx] : 8'($urandom);
            big_if.s_last  = (in_idx == last_at);
            big_if.m_ready = int'($urandom_range(99)) >= bp;
            #1;
            if (big_if.len_err) len_err_cnt++;
            if (big_if.m_valid && big_if.m_parity) par_cycles++;
            if (big_if.s_valid && big_if.s_ready) in_idx++;
            if (big_if.m_valid && big_if.m_ready) begin
                obs_cw[out_cnt] = big_if.m_data;
                if (big_if.m_parity && first_par < 0) first_par = out_cnt;
                if (big_if.m_last) begin
                    last_cnt++;
                    last_idx = out_cnt;
                end
                out_cnt++;
            end
            cyc++;
        end
        check("transfer budget", out_cnt, stop_after);
    endtask

    initial begin
        build_field();
        rst = 1'b1;
        big_if.s_valid = 1'b1; big_if.s_data = 8'hA5; big_if.s_last = 1'b0; big_if.m_ready = 1'b1;
        sm_if.s_valid  = 1'b0; sm_if.s_data  = 4'd0;  sm_if.s_last  = 1'b0; sm_if.m_ready  = 1'b1;

        // Reset: both handshakes forced low even with traffic offered.
        repeat (3) @(negedge clk);
        #1;
        check("reset s_ready", big_if.s_ready, 0);
        check("reset m_valid", big_if.m_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        big_if.s_valid = 1'b0;
        #1;
        check("post-reset s_ready/m_parity", {big_if.s_ready, big_if.m_parity}, 2'b10);
        check("post-reset len_err", big_if.len_err, 0);

        // GF(16), t=1: twelve zeros then 1 gives parity 3, 2.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            sm_if.s_valid = 1'b1;
            sm_if.s_data  = (i == 12) ? 4'd1 : 4'd0;
            sm_if.s_last  = (i == 12);
            #1;
            if (i == 12) check("small pass-through", {sm_if.m_valid, sm_if.m_data}, 5'h11);
        end
        @(negedge clk);
        sm_if.s_valid = 1'b0; sm_if.s_last = 1'b0; sm_if.s_data = 4'hF; sm_if.m_ready = 1'b0;
        #1;
        check("small parity0 data", sm_if.m_data, 3);
        check("small parity0 flags v/p/l/rdy", {sm_if.m_valid, sm_if.m_parity, sm_if.m_last, sm_if.s_ready}, 4'b1100);
        check("small len_err quiet", sm_if.len_err, 0);
        @(negedge clk);
        sm_if.m_ready = 1'b1;
        #1;
        check("small hold under stall", sm_if.m_data, 3);
        @(negedge clk);
        #1;
        check("small parity1 data", sm_if.m_data, 2);
        check("small m_last", sm_if.m_last, 1);
        @(negedge clk);
        #1;
        check("small back to data", {sm_if.m_parity, sm_if.s_ready}, 2'b01);

        // All-zero message: zero parity, 16 parity cycles, one m_last on the final symbol.
        for (int i = 0; i < K; i++) msg[i] = 8'd0;
        build_expected();
        send_big(0, K - 1, N);
        check("zero codeword", cw_mismatches(), 0);
        check("zero parity cycles", par_cycles, P);
        check("zero first parity index", first_par, K);
        check("zero m_last count", last_cnt, 1);
        check("zero m_last index", last_idx, N - 1);

        // m(x) = 1: parity is g[15..0].
        msg[K-1] = 8'd1;
        build_expected();
        send_big(0, K - 1, N);
        for (int k = 0; k < P; k++) check($sformatf("unit parity g[%0d]", P - 1 - k), obs_cw[K + k], gen[P - 1 - k]);
        check("unit model", cw_mismatches(), 0);
        check("unit syndromes", bad_syndromes(), 0);

        // Random message, then the same message under random backpressure on both sides.
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        build_expected();
        send_big(0, K - 1, N);
        check("random model", cw_mismatches(), 0);
        check("random syndromes", bad_syndromes(), 0);
        for (int i = 0; i < N; i++) ref_cw[i] = obs_cw[i];
        send_big(35, K - 1, N);
        begin
            int diff = 0;
            for (int i = 0; i < N; i++) if (obs_cw[i] !== ref_cw[i]) diff++;
            check("backpressure vs free-running", diff, 0);
        end
        check("backpressure syndromes", bad_syndromes(), 0);
        check("backpressure first parity", first_par, K);
        check("backpressure m_last index", last_idx, N - 1);
        check("backpressure len_err", len_err_cnt, 0);

        // s_last early at symbol 100 and absent on the final symbol: two pulses, framing unchanged.
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        build_expected();
        send_big(0, 100, N);
        check("len_err pulses", len_err_cnt, 2);
        check("len_err codeword", cw_mismatches(), 0);

        // Reset after five parity symbols, then an all-zero message must give zero parity.
        send_big(0, K - 1, K + 5);
        @(negedge clk);
        #1;
        check("pre-reset in parity", {big_if.m_valid, big_if.m_parity}, 2'b11);
        rst = 1'b1;
        #1;
        check("reset drops m_valid", big_if.m_valid, 0);
        @(negedge clk);
        #1;
        check("reset returns to data", {big_if.m_valid, big_if.m_parity}, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < K; i++) msg[i] = 8'd0;
        build_expected();
        send_big(0, K - 1, N);
        check("no residue after reset", cw_mismatches(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_encoder.md
# rs_encoder

Parametrised, streaming, systematic Reed-Solomon encoder over GF(2^SYMBOL_BITS), synthesizable successor to the behavioural RS(255,239) model in the `reed_solomon` package. It accepts MESSAGE_LENGTH symbols on a valid/ready stream, passes them through unchanged, then appends 2·CORRECTION_CAPACITY parity symbols computed by an LFSR division by g(x). Symbol width, correction capacity, block length (shortened codes), primitive polynomial and first root b0 are all parameters. The block sits at the transmit-side head of the RS datapath; the package `decode` function is its golden checker.

## Interface
- SYMBOL_BITS, 8, m; field GF(2^m), 3..12
- CORRECTION_CAPACITY, 8, t; parity length 2t
- BLOCK_LENGTH, 255, n; ≤ 2^m−1; smaller values give a shortened code
- PRIM_POLY, 'h11D, primitive polynomial, bit i = coefficient of x^i (degree m)
- B0, 0, g(x) roots α^B0 … α^(B0+2t−1)
- Derived (localparam): PARITY_LEN = 2t, MESSAGE_LENGTH = n − 2t (must be ≥ 1; elaboration error otherwise)
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input symbol valid
- s_ready  out  1  encoder accepts input symbol
- s_data  in  SYMBOL_BITS  message symbol, highest-degree coefficient first
- s_last  in  1  upstream end-of-message marker (checked only, never used for framing)
- m_valid  out  1  output symbol valid
- m_ready  in  1  downstream accepts output
- m_data  out  SYMBOL_BITS  codeword symbol
- m_parity  out  1  current m_data is a parity symbol
- m_last  out  1  last parity symbol of the codeword
- len_err  out  1  one-cycle pulse: s_last disagrees with the message count

## Operation
- Codeword c(x) = m(x)·x^2t + (m(x)·x^2t mod g(x)). Transmit order: message symbols, then parity highest degree first.
- g(x) coefficients are elaboration-time constants, computed by a package function from PRIM_POLY, B0 and t. There are no runtime tables.
- LFSR: 2t registers r[0..2t−1], each m bits. On an accepted message symbol:
  - fb = s_data ^ r[2t−1]
  - r[i] ← r[i−1] ^ g[i]·fb
  - r[0] ← g[0]·fb
  - All products are GF constant multiplies modulo PRIM_POLY.
- FSM has two states:
  - DATA: s_ready = m_ready; m_valid = s_valid; m_data = s_data; m_parity = 0. Transfer happens when s_valid & m_ready. A counter msg_cnt (0..MESSAGE_LENGTH−1) increments per transfer. On the transfer with msg_cnt = MESSAGE_LENGTH−1, go to PARITY and clear msg_cnt.
  - PARITY: s_ready = 0; m_valid = 1; m_data = r[2t−1]; m_parity = 1. On m_ready: r[i] ← r[i−1], r[0] ← 0, par_cnt++. m_last = (par_cnt = 2t−1). On that transfer, return to DATA. The registers are then all zero, so no explicit clear is needed.
- len_err fires one cycle after the offending transfer in either case:
  - s_last = 1 on a transfer with msg_cnt ≠ MESSAGE_LENGTH−1
  - s_last = 0 on the final message transfer
- Framing always follows the count.

## Timing
- Message path is combinational pass-through: 0-cycle latency, no stall bubbles.
- The first parity symbol is valid the cycle after the last message transfer. 2t parity cycles follow at full rate with m_ready high.
- Throughput is n symbols per n cycles at the output. The input is stalled for 2t cycles per codeword.
- Reset values:
  - state = DATA; msg_cnt = par_cnt = 0; r[*] = 0; len_err = 0.
  - While rst is high, s_ready = 0 and m_valid = 0 (forced).
- Reset mid-codeword, in either state: the partial codeword is abandoned and no parity is emitted. The next accepted symbol starts a new codeword.
- With m_ready low in PARITY: m_data, m_parity and m_last hold and the registers do not shift.
- s_data changing while s_ready is low has no effect.

## Structure
- Package `reed_solomon` holds the following; `decode` stays as the bench reference:
  - the parametrised `gf_mul(a, b, m, prim)` function
  - the constant function `rs_gen_poly(m, prim, t, b0)`, returning g[0..2t] in polynomial form
  - the `rs_state_e` enum {DATA, PARITY}
- Sub-module `gf_const_mult`: parameters SYMBOL_BITS, PRIM_POLY, CONST. It is purely combinational XOR network, one instance per g[i] (i = 0..2t−1).

## Test plan
1. t=1, m=4, PRIM_POLY='h13, n=15: send 12 zeros then 1 → parity out 3, 2; m_last on the symbol 2.
2. Default RS(255,239): all-zero message → 16 zero parity symbols, m_parity high for exactly 16 cycles. Then 238 zeros followed by 1 → parity equals g[15..0].
3. Random message with random m_ready/s_valid toggling → codeword bit-identical to the no-backpressure run. The package `decode` returns 0 (no error).
4. Same codeword with 8 injected symbol errors → `decode` returns 1 and restores it. With 9 errors → returns ≠ 0/1, or is miscorrected, and is logged.
5. s_last at symbol 100 → len_err pulses once, encoding continues to 239 symbols. s_last missing at symbol 239 → len_err pulse.
6. rst asserted in PARITY after 5 parity symbols → m_valid 0 next cycle. A fresh all-zero message then yields all-zero parity (no residue).
